// File: rtl/data_ram_arbiter_pkg.sv
// Shared encodings for the data RAM arbiter: FSM states and requester IDs.
package data_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_IF  = 1'b0,
        ARB_MEM = 1'b1
    } arb_port_e;

    localparam int unsigned ARB_LANES = 4;

endpackage

// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter in front of the single-port synchronous data RAM.
// IF (read-only) and MEM (load/store) share the RAM; round-robin on contention.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RAM_AW = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic                 if_ack,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_stall,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [3:0]           mem_sel,
    input  logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_ack,
    output logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_stall,
    output logic                 ram_ce,
    output logic                 ram_we,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [3:0]           ram_sel,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    arb_state_e          state_q, state_d;
    arb_port_e           last_q, last_d;
    arb_port_e           winner_q, winner_d;
    logic                ram_ce_q, ram_ce_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [3:0]          ram_sel_q, ram_sel_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

    logic                do_issue;
    arb_port_e           next_port;
    arb_port_e           other_port;
    logic                other_req;

    // Byte-offset and out-of-range address bits carry no meaning for a word RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[ADDR_W-1:RAM_AW+2],
                                mem_addr[1:0], mem_addr[ADDR_W-1:RAM_AW+2]};

    // Single requester wins outright; on contention the port that was not served last wins.
    function automatic arb_port_e pick_winner(input logic if_r, input logic mem_r,
                                              input arb_port_e last);
        if (if_r && mem_r) begin
            return (last == ARB_IF) ? ARB_MEM : ARB_IF;
        end else if (mem_r) begin
            return ARB_MEM;
        end else begin
            return ARB_IF;
        end
    endfunction

    assign other_port = (winner_q == ARB_IF) ? ARB_MEM : ARB_IF;
    assign other_req  = (winner_q == ARB_IF) ? mem_req : if_req;

    // Next-state and RAM command computation; WAIT hands straight over to the other port.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        ram_ce_d    = ram_ce_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_sel_d   = ram_sel_q;
        ram_wdata_d = ram_wdata_q;
        do_issue    = 1'b0;
        next_port   = winner_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (if_req || mem_req) begin
                    do_issue  = 1'b1;
                    next_port = pick_winner(if_req, mem_req, last_q);
                end
            end
            ARB_ISSUE: begin
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = ARB_WAIT;
            end
            ARB_WAIT: begin
                last_d = winner_q;
                if (other_req) begin
                    do_issue  = 1'b1;
                    next_port = other_port;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase

        if (do_issue) begin
            state_d     = ARB_ISSUE;
            winner_d    = next_port;
            ram_ce_d    = 1'b1;
            ram_we_d    = (next_port == ARB_MEM) && mem_we;
            ram_addr_d  = (next_port == ARB_MEM) ? mem_addr[RAM_AW+1:2] : if_addr[RAM_AW+1:2];
            ram_sel_d   = ((next_port == ARB_MEM) && mem_we) ? mem_sel : 4'hF;
            ram_wdata_d = (next_port == ARB_MEM) ? mem_wdata : '0;
        end
    end

    // State and registered RAM command; asynchronous clear abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            last_q      <= ARB_IF;
            winner_q    <= ARB_IF;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_sel_q   <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_sel_q   <= ram_sel_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_sel   = ram_sel_q;
    assign ram_wdata = ram_wdata_q;

    assign if_ack    = (state_q == ARB_WAIT) && (winner_q == ARB_IF);
    assign mem_ack   = (state_q == ARB_WAIT) && (winner_q == ARB_MEM);
    assign if_rdata  = ram_rdata;
    assign mem_rdata = ram_rdata;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: per-port expectation queues filled at
// request time from a word-array reference model, drained by a negedge monitor.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        ram_ce;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] tb_ram  [0:255];
    logic [31:0] ref_ram [0:255];
    logic [31:0] if_exp[$];
    logic [31:0] mem_exp_data[$];
    bit          mem_exp_load[$];
    int          grant_log[$];
    int          if_ack_cnt = 0;
    int          mem_ack_cnt = 0;
    logic [31:0] last_load_data = '0;

    data_ram_arbiter #(.DATA_W(32), .ADDR_W(32), .RAM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with byte-lane writes.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) tb_ram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= tb_ram[ram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Monitor: protocol invariants every cycle, data checked against queued expectations on acks.
    always @(negedge clk) begin
        if (!rst) begin
            chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~if_ack});
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~mem_ack});
            if (if_ack && mem_ack) chk("ack_exclusive", 32'd1, 32'd0);
            if (if_ack) begin
                if_ack_cnt++;
                grant_log.push_back(0);
                if (if_exp.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
                else chk("if_rdata", if_rdata, if_exp.pop_front());
            end
            if (mem_ack) begin
                mem_ack_cnt++;
                grant_log.push_back(1);
                if (mem_exp_data.size() == 0) chk("mem_ack_unexpected", 32'd1, 32'd0);
                else begin
                    logic [31:0] e;
                    bit          ld;
                    e  = mem_exp_data.pop_front();
                    ld = mem_exp_load.pop_front();
                    if (ld) begin
                        chk("mem_rdata", mem_rdata, e);
                        last_load_data = mem_rdata;
                    end
                end
            end
        end
    end

    // Caller sits just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic if_access(input logic [31:0] addr);
        bit got;
        got = 0;
        if_req  = 1'b1;
        if_addr = addr;
        if_exp.push_back(ref_ram[addr[9:2]]);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_ack) begin got = 1; break; end
        end
        if (!got) chk("if_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wd);
        bit got;
        got = 0;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wd;
        if (we) begin
            ref_ram[addr[9:2]] = merge(ref_ram[addr[9:2]], wd, sel);
            mem_exp_load.push_back(0);
            mem_exp_data.push_back('0);
        end else begin
            mem_exp_load.push_back(1);
            mem_exp_data.push_back(ref_ram[addr[9:2]]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_ack) begin got = 1; break; end
        end
        if (!got) chk("mem_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_ram_addr", {15'b0, ram_addr}, 32'd0);
        chk("rst_ram_sel", {28'b0, ram_sel}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_acks", {30'b0, if_ack, mem_ack}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_if_addr();
        logic [31:0] w;
        w = 32'($urandom_range(128, 255));
        return ($urandom & 32'hFFF8_0000) | (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_mem_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 127));
        return ($urandom & 32'hFFF8_0000) | (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int ifc0, mc0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            tb_ram[i] = v;
            ref_ram[i] = v;
        end
        tb_ram[0] = 32'h0;          ref_ram[0] = 32'h0;
        tb_ram[4] = 32'h4455_6677;  ref_ram[4] = 32'h4455_6677;

        do_reset();

        // 1: single IF read with cycle-exact timing
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        if_exp.push_back(ref_ram[4]);
        @(negedge clk);
        chk("t1_ce_before_edge", {31'b0, ram_ce}, 32'd0);
        @(negedge clk);
        chk("t1_ram_ce", {31'b0, ram_ce}, 32'd1);
        chk("t1_ram_addr", {15'b0, ram_addr}, 32'd4);
        chk("t1_ram_sel", {28'b0, ram_sel}, 32'hF);
        chk("t1_ram_we", {31'b0, ram_we}, 32'd0);
        chk("t1_if_stall", {31'b0, if_stall}, 32'd1);
        @(negedge clk);
        chk("t1_if_ack", {31'b0, if_ack}, 32'd1);
        chk("t1_ram_ce_low", {31'b0, ram_ce}, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;

        // 2/3: partial-lane stores then full-word loads
        mem_access(1'b1, 32'h0, 4'b0011, 32'h0000_EEFF);
        mem_access(1'b0, 32'h0, 4'hF, 32'h0);
        chk("t2_load", last_load_data, 32'h0000_EEFF);
        mem_access(1'b1, 32'h0, 4'b0100, 32'h00CC_0000);
        mem_access(1'b0, 32'h0, 4'hF, 32'h0);
        chk("t3_load", last_load_data, 32'h00CC_EEFF);
        mem_access(1'b1, 32'h8, 4'b0000, 32'hDEAD_BEEF);
        mem_access(1'b0, 32'h8, 4'hF, 32'h0);

        // 4: contention from reset, grants must alternate starting with MEM
        do_reset();
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) if_access(rand_if_addr());
            for (int i = 0; i < 3; i++) mem_access(1'b0, rand_mem_addr(), 4'hF, 32'h0);
        join
        chk("t4_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("t4_grant_order", 32'(grant_log[i]), 32'((i % 2 == 0) ? 1 : 0));

        // 5: MEM alone, back-to-back loads
        ifc0 = if_ack_cnt;
        mc0  = mem_ack_cnt;
        for (int i = 0; i < 4; i++) mem_access(1'b0, rand_mem_addr(), 4'hF, 32'h0);
        chk("t5_mem_acks", 32'(mem_ack_cnt - mc0), 32'd4);
        chk("t5_no_if_ack", 32'(if_ack_cnt - ifc0), 32'd0);

        // 6: reset during the ISSUE cycle of a store; store must not land
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0; mem_sel = 4'hF; mem_wdata = 32'hAABB_88BB;
        @(negedge clk);
        @(negedge clk);
        chk("t6_issue_ce", {31'b0, ram_ce}, 32'd1);
        chk("t6_issue_we", {31'b0, ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_ce_dropped", {31'b0, ram_ce}, 32'd0);
        chk("t6_no_ack", {30'b0, if_ack, mem_ack}, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_access(1'b0, 32'h0, 4'hF, 32'h0);
        chk("t6_old_word", last_load_data, 32'h00CC_EEFF);

        // Random traffic on both ports (IF reads upper words, MEM works on lower words)
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if_access(rand_if_addr());
            end
            for (int i = 0; i < 50; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                mem_access(1'($urandom_range(0, 1)), rand_mem_addr(), 4'($urandom), $urandom);
            end
        join

        repeat (4) @(posedge clk);
        chk("end_if_queue", 32'(if_exp.size()), 32'd0);
        chk("end_mem_queue", 32'(mem_exp_data.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
